// File: rtl/tlul_dma_copy_pkg.sv
// rtl/tlul_dma_copy_pkg.sv - State type and constants for the TL-UL block copy engine.
package tlul_dma_copy_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_REQ = 3'd1,
      RD_RSP = 3'd2,
      WR_REQ = 3'd3,
      WR_RSP = 3'd4,
      FIN    = 3'd5
   } dma_state_e;

   localparam logic [31:0] WordBytes = 32'd4;
   localparam logic [3:0]  FullMask  = 4'hF;

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types, opcodes and integrity folding helper.
package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   typedef struct packed {
      logic [6:0] rsp_intg;
      logic [6:0] data_intg;
   } tl_d_user_t;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      tl_a_user_t  a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      tl_d_user_t  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   // XOR-fold of 64 bits into a 7-bit check code, shared by generator and checker.
   function automatic logic [6:0] fold_intg(input logic [63:0] v);
      logic [6:0] acc;
      acc = 7'h7F;
      for (int i = 0; i < 10; i++) acc = acc ^ 7'(v >> (7 * i));
      return acc;
   endfunction

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// rtl/tlul_cmd_intg_gen.sv - Fills A-channel a_user with command and data integrity codes.
module tlul_cmd_intg_gen
   import tlul_pkg::*;
(
   input  tl_h2d_t tl_i,
   output tl_h2d_t tl_o
);

   always_comb begin
      tl_o = tl_i;
      tl_o.a_user.cmd_intg  = fold_intg({15'h0, tl_i.a_opcode, tl_i.a_address, tl_i.a_mask,
                                         tl_i.a_size, tl_i.a_source});
      tl_o.a_user.data_intg = fold_intg({32'h0, tl_i.a_data});
   end

endmodule

// File: rtl/tlul_rsp_intg_chk.sv
// rtl/tlul_rsp_intg_chk.sv - Flags a D-channel response whose d_user integrity does not match.
module tlul_rsp_intg_chk
   import tlul_pkg::*;
(
   input  tl_d2h_t tl_i,
   output logic    err_o
);

   logic [6:0] rsp_exp;
   logic [6:0] data_exp;
   logic       unused_tl;

   assign rsp_exp   = fold_intg({50'h0, tl_i.d_opcode, tl_i.d_size, tl_i.d_source, tl_i.d_error});
   assign data_exp  = fold_intg({32'h0, tl_i.d_data});
   assign err_o     = (rsp_exp != tl_i.d_user.rsp_intg) || (data_exp != tl_i.d_user.data_intg);
   assign unused_tl = ^tl_i;

endmodule

// File: rtl/tlul_dma_copy.sv
// rtl/tlul_dma_copy.sv - TL-UL host engine copying 32-bit words, one transaction in flight.
// Response integrity checking is enabled by TLUL_DMA_COPY_RSP_INTG_CHK_EN.
module tlul_dma_copy
   import tlul_pkg::*;
   import tlul_dma_copy_pkg::*;
#(
   parameter int unsigned LenW     = 16,
   parameter logic [7:0]  SourceId = 8'h00
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [31:0]     src_addr_i,
   input  logic [31:0]     dst_addr_i,
   input  logic [LenW-1:0] len_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output tl_h2d_t         tl_h_o,
   input  tl_d2h_t         tl_h_i
);

   dma_state_e      state_q, state_d;
   logic [31:0]     src_q, dst_q, data_q;
   logic [LenW-1:0] cnt_q;
   logic            err_q;
   logic            misaligned, a_hs, d_hs, rsp_bad, intg_err;
   logic [2:0]      exp_d_op;
   tl_h2d_t         tl_raw;
   logic            unused_tl;

   assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
   assign a_hs       = tl_raw.a_valid & tl_h_i.a_ready;
   assign d_hs       = tl_raw.d_ready & tl_h_i.d_valid;
   assign exp_d_op   = (state_q == RD_RSP) ? AccessAckData : AccessAck;
   // A response that is not addressed to us or has the wrong shape counts as a bus error.
   assign rsp_bad    = tl_h_i.d_error || (tl_h_i.d_source != SourceId) ||
                       (tl_h_i.d_opcode != exp_d_op) || intg_err;
   assign unused_tl  = ^{tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink, tl_h_i.d_user};

`ifdef TLUL_DMA_COPY_RSP_INTG_CHK_EN
   tlul_rsp_intg_chk u_rsp_intg_chk (
      .tl_i  (tl_h_i),
      .err_o (intg_err)
   );
`else
   assign intg_err = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = (misaligned || len_i == '0) ? FIN : RD_REQ;
         RD_REQ:  if (a_hs) state_d = RD_RSP;
         RD_RSP:  if (d_hs) state_d = rsp_bad ? FIN : WR_REQ;
         WR_REQ:  if (a_hs) state_d = WR_RSP;
         WR_RSP:  if (d_hs) state_d = (rsp_bad || cnt_q == LenW'(1)) ? FIN : RD_REQ;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_q  <= '0;
         dst_q  <= '0;
         data_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               src_q <= src_addr_i;
               dst_q <= dst_addr_i;
               cnt_q <= len_i;
               err_q <= misaligned;
            end
            RD_RSP: if (d_hs) begin
               if (rsp_bad) err_q  <= 1'b1;
               else         data_q <= tl_h_i.d_data;
            end
            WR_RSP: if (d_hs) begin
               if (rsp_bad) begin
                  err_q <= 1'b1;
               end else begin
                  src_q <= src_q + WordBytes;
                  dst_q <= dst_q + WordBytes;
                  cnt_q <= cnt_q - LenW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Request fields come straight from registers that only move in IDLE/*_RSP, so they hold under backpressure.
   always_comb begin
      tl_raw          = '0;
      tl_raw.a_size   = 2'd2;
      tl_raw.a_mask   = FullMask;
      tl_raw.a_source = SourceId;
      busy_o          = (state_q != IDLE);
      done_o          = (state_q == FIN);
      case (state_q)
         RD_REQ: begin
            tl_raw.a_valid   = 1'b1;
            tl_raw.a_opcode  = Get;
            tl_raw.a_address = src_q;
         end
         WR_REQ: begin
            tl_raw.a_valid   = 1'b1;
            tl_raw.a_opcode  = PutFullData;
            tl_raw.a_address = dst_q;
            tl_raw.a_data    = data_q;
         end
         RD_RSP, WR_RSP: tl_raw.d_ready = 1'b1;
         default: ;
      endcase
   end

   tlul_cmd_intg_gen u_cmd_intg_gen (
      .tl_i (tl_raw),
      .tl_o (tl_h_o)
   );

   assign err_o = err_q;

endmodule

// File: tb/tb_tlul_dma_copy.sv
// tb/tb_tlul_dma_copy.sv - Randomized bench with a word-memory responder and request-list model.
module tb_tlul_dma_copy;
   import tlul_pkg::*;

   localparam int         LenW = 16;
   localparam logic [7:0] Sid  = 8'h3C;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [31:0]     src = '0, dst = '0;
   logic [LenW-1:0] len = '0;
   logic            busy, done, err;
   tl_h2d_t         tl_h2d;
   tl_d2h_t         tl_d2h;

   always #5 clk = ~clk;

   tlul_dma_copy #(.LenW(LenW), .SourceId(Sid)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .src_addr_i(src), .dst_addr_i(dst),
      .len_i(len), .busy_o(busy), .done_o(done), .err_o(err), .tl_h_o(tl_h2d), .tl_h_i(tl_d2h)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   int          errors = 0, checks = 0;
   logic [31:0] mem [0:1023];
   req_t        exp_q[$];
   logic [31:0] os_q[$], od_q[$];
   int          m_nreq, m_nwr, req_cnt, exp_total, fault_kind, fault_at;
   bit          m_err, stall_mode, outstanding, pend;
   int          a_wait, d_delay, pend_fault;
   logic [2:0]  pend_op;
   logic [7:0]  pend_src;
   logic [31:0] pend_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, expv);
      end
   endtask

   function automatic logic [9:0] widx(input logic [31:0] a);
      return a[11:2];
   endfunction

   // Full ordered request list of a copy, cut short at the faulting request.
   task automatic prepare_model(input logic [31:0] s, input logic [31:0] d, input int n,
                                input int fk, input int fat);
      bit misal;
      misal  = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
      m_nreq = misal ? 0 : 2 * n;
      m_err  = misal;
      if (!misal && fk != 0 && fat >= 1 && fat <= m_nreq) begin
         m_nreq = fat;
         m_err  = 1'b1;
      end
      m_nwr = m_nreq / 2;
      os_q.delete(); od_q.delete(); exp_q.delete();
      for (int i = 0; i < n; i++) begin
         os_q.push_back(mem[widx(s + 32'(4 * i))]);
         od_q.push_back(mem[widx(d + 32'(4 * i))]);
      end
      for (int r = 0; r < m_nreq; r++) begin
         req_t e;
         int   wi;
         wi = r / 2;
         if (r % 2 == 0) begin
            e.op = 3'(Get); e.addr = s + 32'(4 * wi); e.data = '0;
         end else begin
            e.op = 3'(PutFullData); e.addr = d + 32'(4 * wi); e.data = os_q[wi];
         end
         exp_q.push_back(e);
      end
      req_cnt = 0; exp_total = m_nreq; fault_kind = fk; fault_at = fat;
   endtask

   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int fk,
                           input int fat, input bit stall, input int exp_lat, output int lat);
      int cyc;
      bit seen;
      prepare_model(s, d, n, fk, fat);
      stall_mode = stall;
      @(negedge clk);
      src = s; dst = d; len = LenW'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0; src = $urandom; dst = $urandom; len = LenW'($urandom);
      cyc = 1; seen = 1'b0;
      while (!seen && cyc < 3000) begin
         start = (cyc == 2);
         if (done) seen = 1'b1;
         else begin
            chk("busy_during_copy", 32'(busy), 32'd1);
            chk("err_clear_during_copy", 32'(err), 32'd0);
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      lat = cyc;
      chk("done_seen", 32'(seen), 32'd1);
      if (seen) begin
         chk("busy_at_done", 32'(busy), 32'd1);
         chk("err_at_done", 32'(err), 32'(m_err));
         if (exp_lat >= 0) chk("latency", 32'(cyc), 32'(exp_lat));
         @(negedge clk);
         chk("done_single_pulse", 32'(done), 32'd0);
         chk("busy_after_done", 32'(busy), 32'd0);
         chk("err_sticky", 32'(err), 32'(m_err));
         chk("requests_left", 32'(exp_q.size()), 32'd0);
         chk("request_total", 32'(req_cnt), 32'(m_nreq));
         for (int i = 0; i < n; i++)
            chk("dst_word", mem[widx(d + 32'(4 * i))], (i < m_nwr) ? os_q[i] : od_q[i]);
      end
   endtask

   // Responder and per-cycle protocol checker; works from values sampled just after each edge.
   initial begin : responder
      tl_h2d_t sa;
      logic    s_ar, s_dv;
      req_t    e;
      tl_d2h = '0; tl_d2h.a_ready = 1'b1;
      sa = '0; s_ar = 1'b0; s_dv = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            pend = 1'b0; outstanding = 1'b0; a_wait = 0;
            sa = '0; s_ar = 1'b0; s_dv = 1'b0;
            tl_d2h = '0; tl_d2h.a_ready = 1'b1;
            continue;
         end
         if (s_dv && sa.d_ready) begin
            pend = 1'b0; outstanding = 1'b0; tl_d2h.d_valid = 1'b0;
         end
         if (sa.a_valid && s_ar) begin
            req_cnt++;
            if (exp_q.size() == 0) chk("request_count", 32'(req_cnt), 32'(exp_total));
            else begin
               e = exp_q.pop_front();
               chk("a_opcode", 32'(sa.a_opcode), 32'(e.op));
               chk("a_address", sa.a_address, e.addr);
               if (e.op == 3'(PutFullData)) chk("a_data", sa.a_data, e.data);
            end
            chk("a_mask", 32'(sa.a_mask), 32'hF);
            chk("a_size", 32'(sa.a_size), 32'd2);
            chk("a_source", 32'(sa.a_source), 32'(Sid));
            if (sa.a_opcode == 3'(Get)) begin
               pend_data = mem[widx(sa.a_address)];
               pend_op   = 3'(AccessAckData);
            end else begin
               mem[widx(sa.a_address)] = sa.a_data;
               pend_data = '0;
               pend_op   = 3'(AccessAck);
            end
            pend_src    = sa.a_source;
            pend_fault  = (req_cnt == fault_at) ? fault_kind : 0;
            pend        = 1'b1;
            outstanding = 1'b1;
            d_delay = stall_mode ? $urandom_range(0, 5) : 0;
            a_wait  = stall_mode ? $urandom_range(0, 5) : 0;
         end
         chk("d_ready", 32'(tl_h2d.d_ready), 32'(outstanding));
         if (!busy) chk("a_valid_idle", 32'(tl_h2d.a_valid), 32'd0);
         if (sa.a_valid && !s_ar) begin
            chk("a_valid_hold", 32'(tl_h2d.a_valid), 32'd1);
            chk("a_opcode_hold", 32'(tl_h2d.a_opcode), 32'(sa.a_opcode));
            chk("a_address_hold", tl_h2d.a_address, sa.a_address);
            chk("a_data_hold", tl_h2d.a_data, sa.a_data);
         end
         if (pend && !tl_d2h.d_valid) begin
            if (d_delay == 0) begin
               tl_d2h.d_valid  = 1'b1;
               tl_d2h.d_opcode = pend_op ^ ((pend_fault == 3) ? 3'h2 : 3'h0);
               tl_d2h.d_source = pend_src ^ ((pend_fault == 2) ? 8'h80 : 8'h00);
               tl_d2h.d_error  = (pend_fault == 1);
               tl_d2h.d_size   = 2'd2;
               tl_d2h.d_data   = pend_data;
               tl_d2h.d_user.rsp_intg  = fold_intg({50'h0, tl_d2h.d_opcode, tl_d2h.d_size,
                                                    tl_d2h.d_source, tl_d2h.d_error});
               tl_d2h.d_user.data_intg = fold_intg({32'h0, tl_d2h.d_data});
            end else d_delay--;
         end
         if (a_wait > 0) begin
            tl_d2h.a_ready = 1'b0;
            if (tl_h2d.a_valid) a_wait--;
         end else tl_d2h.a_ready = 1'b1;
         sa = tl_h2d; s_ar = tl_d2h.a_ready; s_dv = tl_d2h.d_valid;
      end
   end

   initial begin : main
      int  lat, n;
      bit  found;
      logic [31:0] s;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[64] = 32'hA5A5_0001;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_a_valid", 32'(tl_h2d.a_valid), 32'd0);
      chk("rst_d_ready", 32'(tl_h2d.d_ready), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_copy(32'h100, 32'h200, 4, 0, 0, 1'b0, 17, lat);
      chk("pin_lat_len4", 32'(lat), 32'd17);
      chk("pin_dst_first", mem[widx(32'h200)], 32'hA5A5_0001);

      run_copy(32'h300, 32'h340, 0, 0, 0, 1'b0, 1, lat);
      chk("pin_lat_len0", 32'(lat), 32'd1);

      run_copy(32'h102, 32'h200, 3, 0, 0, 1'b0, 1, lat);
      chk("pin_err_misaligned", 32'(err), 32'd1);
      run_copy(32'h500, 32'h600, 3, 0, 0, 1'b0, 13, lat);
      chk("pin_err_cleared", 32'(err), 32'd0);
      run_copy(32'h100, 32'h201, 2, 0, 0, 1'b0, 1, lat);

      run_copy(32'h040, 32'h0C0, 5, 1, 5, 1'b0, -1, lat);
      run_copy(32'h700, 32'h780, 3, 2, 4, 1'b0, -1, lat);
      run_copy(32'h700, 32'h780, 3, 3, 1, 1'b0, -1, lat);
      run_copy(32'hFFFF_FFF8, 32'h400, 4, 0, 0, 1'b0, 17, lat);

      run_copy(32'h000, 32'h800, 16, 0, 0, 1'b1, -1, lat);
      for (int k = 0; k < 4; k++) begin
         s = {22'h0, 8'($urandom_range(0, 150)), 2'b00};
         n = $urandom_range(1, 16);
         run_copy(s, s + 32'h800, n, (k == 3) ? 1 : 0, $urandom_range(1, 2 * n), 1'b1, -1, lat);
      end

      prepare_model(32'h700, 32'h780, 4, 0, 0);
      stall_mode = 1'b0;
      @(negedge clk);
      src = 32'h700; dst = 32'h780; len = LenW'(4); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         if (tl_h2d.a_valid && tl_h2d.a_opcode == 3'(PutFullData)) found = 1'b1;
         else @(negedge clk);
      end
      chk("reached_wr_req", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_a_valid", 32'(tl_h2d.a_valid), 32'd0);
      chk("rst_mid_d_ready", 32'(tl_h2d.d_ready), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_err", 32'(err), 32'd0);
      repeat (2) @(negedge clk);
      run_copy(32'h700, 32'h780, 4, 0, 0, 1'b0, 17, lat);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
